rs_alu_sched: RTL



---
 rtl/rs_alu_sched.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rs_alu_sched.sv
// ALU reservation-station scheduler: picks free entries for two dispatch slots and
// issues the oldest ready entry using an age matrix.
`ifndef RS_ALU_ENT_NUM
`define RS_ALU_ENT_NUM 2
`endif
`ifndef RS_ALU_ENT_SEL
`define RS_ALU_ENT_SEL 1
`endif

module rs_alu_sched #(
  parameter int unsigned ENT_NUM = `RS_ALU_ENT_NUM,
  parameter int unsigned ENT_SEL = `RS_ALU_ENT_SEL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ENT_NUM-1:0] i_busy_vec,
  input  logic [ENT_NUM-1:0] i_vld_vec,
  input  logic               i_req_1,
  input  logic               i_req_2,
  input  logic               i_stall,
  output logic               o_alloc_vld_1,
  output logic [ENT_SEL-1:0] o_alloc_sel_1,
  output logic               o_alloc_vld_2,
  output logic [ENT_SEL-1:0] o_alloc_sel_2,
  output logic               o_full,
  input  logic               i_ex_rdy,
  output logic               o_is_vld,
  output logic [ENT_SEL-1:0] o_is_sel
);

  // age_q[i][j] = 1 means entry i is older than entry j.
  logic [ENT_NUM-1:0] age_q [ENT_NUM];
  logic [ENT_NUM-1:0] age_d [ENT_NUM];

  logic [ENT_NUM-1:0] free;
  logic [ENT_NUM-1:0] free_2;
  logic               found_1;
  logic               found_2;
  logic [ENT_SEL-1:0] idx_1;
  logic [ENT_SEL-1:0] idx_2;
  int unsigned        req_cnt;

  always_comb begin
    free    = ~i_busy_vec;
    found_1 = 1'b0;
    idx_1   = '0;
    // Descending scan so the last hit is the lowest free index.
    for (int i = int'(ENT_NUM) - 1; i >= 0; i--) begin
      if (free[i]) begin
        found_1 = 1'b1;
        idx_1   = ENT_SEL'(i);
      end
    end

    free_2 = free;
    if (i_req_1 && found_1) begin
      free_2[idx_1] = 1'b0;
    end
    found_2 = 1'b0;
    idx_2   = '0;
    for (int i = int'(ENT_NUM) - 1; i >= 0; i--) begin
      if (free_2[i]) begin
        found_2 = 1'b1;
        idx_2   = ENT_SEL'(i);
      end
    end

    o_alloc_vld_1 = i_req_1 & found_1;
    o_alloc_sel_1 = o_alloc_vld_1 ? idx_1 : '0;
    o_alloc_vld_2 = i_req_2 & found_2;
    o_alloc_sel_2 = o_alloc_vld_2 ? idx_2 : '0;

    req_cnt = 32'(i_req_1) + 32'(i_req_2);
    o_full  = req_cnt > 32'($countones(free));
  end

  always_comb begin
    for (int i = 0; i < int'(ENT_NUM); i++) begin
      age_d[i] = age_q[i];
    end
    if (!i_stall) begin
      // Slot 1 first, then slot 2, so slot 2 ends up younger than slot 1.
      if (o_alloc_vld_1) begin
        age_d[o_alloc_sel_1] = '0;
        for (int j = 0; j < int'(ENT_NUM); j++) begin
          if (j != int'(o_alloc_sel_1)) begin
            age_d[j][o_alloc_sel_1] = 1'b1;
          end
        end
      end
      if (o_alloc_vld_2) begin
        age_d[o_alloc_sel_2] = '0;
        for (int j = 0; j < int'(ENT_NUM); j++) begin
          if (j != int'(o_alloc_sel_2)) begin
            age_d[j][o_alloc_sel_2] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENT_NUM); i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(ENT_NUM); i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  logic               cand_ok;
  logic               cand_found;
  logic [ENT_SEL-1:0] cand_idx;

  always_comb begin
    cand_ok    = 1'b0;
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int i = 0; i < int'(ENT_NUM); i++) begin
      cand_ok = i_vld_vec[i];
      for (int j = 0; j < int'(ENT_NUM); j++) begin
        if (j != i && i_vld_vec[j] && !age_q[i][j]) begin
          cand_ok = 1'b0;
        end
      end
      if (cand_ok && !cand_found) begin
        cand_found = 1'b1;
        cand_idx   = ENT_SEL'(i);
      end
    end
    o_is_vld = i_ex_rdy & (|i_vld_vec);
    o_is_sel = cand_idx;
  end

endmodule
